sm_pi_pipe: RTL and testbench

SM_PI_PIPE -- requirements
Module: sm_pi_pipe

---
 rtl/sm_pi_pipe.sv | 167 ++++++++++++++++
 tb/tb_sm_pi_pipe.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_pi_pipe.sv
// sm_pi_pipe: Keccak pi permutation (forward or inverse) on a 5x5 lane state,
// computed combinationally at the input and held in a DEPTH-entry output FIFO.
// Optional feature macro: SM_PI_PIPE_RHO_EN. When defined, forward mode applies
// rho (lane rotate-left) before pi and inverse mode applies rho rotate-right after
// inverse pi, so inverse(forward(S)) == S in both builds.
module sm_pi_pipe #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_inv,
  input  logic [25*W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [25*W-1:0] out_data,
  output logic            out_inv,
  output logic            busy
);

  localparam int            CW       = $clog2(DEPTH + 1);
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  generate
    if (!(W == 8 || W == 16 || W == 32 || W == 64)) begin : g_bad_w
      $error("sm_pi_pipe: W must be 8, 16, 32 or 64");
    end
    if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
      $error("sm_pi_pipe: DEPTH must be in 2..8");
    end
  endgenerate

  // Lane index that pi pairs with (x,y): lane (x+3y mod 5, x), packed as 5*row+col.
  function automatic int unsigned pi_idx(input int unsigned x, input int unsigned y);
    return 5 * x + (x + 3 * y) % 5;
  endfunction

`ifdef SM_PI_PIPE_RHO_EN
  // FIPS 202 rho offsets, indexed by 5*y+x.
  localparam int unsigned RHO_OFF [25] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int unsigned n);
    logic [2*W-1:0] d;
    d = {v, v} << n;
    return d[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int unsigned n);
    logic [2*W-1:0] d;
    d = {v, v} >> n;
    return d[W-1:0];
  endfunction
`endif

  logic [25*W-1:0] xf_data;

  logic [25*W-1:0] mem_data_q [DEPTH];
  logic            mem_inv_q  [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   last_ptr_q, last_ptr_d;
  logic [PW-1:0]   out_sel;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            push, pop;

  // Transform of the offered state; forward walks destinations, inverse walks sources.
  always_comb begin
    xf_data = '0;
    for (int unsigned y = 0; y < 5; y++) begin
      for (int unsigned x = 0; x < 5; x++) begin
        if (!in_inv) begin
`ifdef SM_PI_PIPE_RHO_EN
          xf_data[(5*y+x)*W +: W] = rotl(in_data[pi_idx(x, y)*W +: W],
                                         RHO_OFF[pi_idx(x, y)] % W);
`else
          xf_data[(5*y+x)*W +: W] = in_data[pi_idx(x, y)*W +: W];
`endif
        end else begin
`ifdef SM_PI_PIPE_RHO_EN
          xf_data[pi_idx(x, y)*W +: W] = rotr(in_data[(5*y+x)*W +: W],
                                              RHO_OFF[pi_idx(x, y)] % W);
`else
          xf_data[pi_idx(x, y)*W +: W] = in_data[(5*y+x)*W +: W];
`endif
        end
      end
    end
  end

  assign out_valid = (count_q != '0);
  assign busy      = out_valid;
  assign in_ready  = in_ready_q;

  // When empty, keep showing the slot that was popped last so out_data holds its value.
  assign out_sel   = out_valid ? rd_ptr_q : last_ptr_q;
  assign out_data  = mem_data_q[out_sel];
  assign out_inv   = mem_inv_q[out_sel];

  // FIFO pointer, occupancy and registered-ready next state.
  always_comb begin
    push       = in_valid && in_ready_q;
    pop        = out_valid && out_ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_ptr_d = last_ptr_q;
    count_d    = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
      last_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Ready is registered from next occupancy, so out_ready never reaches in_ready combinationally.
    in_ready_d = (count_d < DEPTH_C);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_ptr_q <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_ptr_q <= last_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Buffer storage; cleared on reset so out_data reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_inv_q[i]  <= 1'b0;
      end
    end else if (push) begin
      mem_data_q[wr_ptr_q] <= xf_data;
      mem_inv_q[wr_ptr_q]  <= in_inv;
    end
  end

  a_count_max : assert property (@(posedge clk) disable iff (!rst_n) count_q <= DEPTH_C);
  a_ready_cnt : assert property (@(posedge clk) disable iff (!rst_n) in_ready_q |-> count_q < DEPTH_C);

endmodule

// File: tb/tb_sm_pi_pipe.sv
// tb_sm_pi_pipe: randomized and directed checks of sm_pi_pipe against a lane-level model.
// Instance A: W=64 DEPTH=2; instance B: W=16 DEPTH=3. Build with SM_PI_PIPE_RHO_EN to test rho.
module tb_sm_pi_pipe;

`ifdef SM_PI_PIPE_RHO_EN
  localparam bit RHO = 1'b1;
`else
  localparam bit RHO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv, a_busy;
  logic [1599:0] a_in_data, a_out_data;
  logic          b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv, b_busy;
  logic [399:0]  b_in_data, b_out_data;

  sm_pi_pipe #(.W(64), .DEPTH(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_inv(a_out_inv), .busy(a_busy)
  );

  sm_pi_pipe #(.W(16), .DEPTH(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_inv(b_out_inv), .busy(b_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [1600:0] got, input logic [1600:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      for (int i = 0; i < 26; i++) begin
        if (got[i*64 +: 64] !== exp[i*64 +: 64]) begin
          $display("FAIL %s: word %0d got %h expected %h", tag, i, got[i*64 +: 64], exp[i*64 +: 64]);
          break;
        end
      end
    end
  endtask

  // Rho offset by walking the FIPS 202 (x,y) sequence.
  function automatic int rho_off(input int x, input int y);
    int cx, cy, nx;
    cx = 1; cy = 0;
    if (x == 0 && y == 0) return 0;
    for (int t = 0; t < 24; t++) begin
      if (cx == x && cy == y) return (t + 1) * (t + 2) / 2;
      nx = cy;
      cy = (2 * cx + 3 * cy) % 5;
      cx = nx;
    end
    return 0;
  endfunction

  function automatic logic [63:0] rot_left(input logic [63:0] v, input int n, input int w);
    logic [63:0] r;
    r = '0;
    for (int z = 0; z < w; z++) r[(z + n) % w] = v[z];
    return r;
  endfunction

  // Reference: forward out(x,y) = rho(in((x+3y)%5, x)); inverse undoes it exactly.
  function automatic logic [1599:0] model(input logic [1599:0] v, input bit inv, input int w);
    logic [63:0]   a [5][5];
    logic [63:0]   b [5][5];
    logic [1599:0] r;
    int sx, sh;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        a[x][y] = '0;
        b[x][y] = '0;
        for (int z = 0; z < w; z++) a[x][y][z] = v[(5*y+x)*w + z];
      end
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        sx = (x + 3*y) % 5;
        sh = RHO ? rho_off(sx, x) % w : 0;
        if (!inv) b[x][y] = rot_left(a[sx][x], sh, w);
        else      b[sx][x] = rot_left(a[x][y], w - sh, w);
      end
    r = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int z = 0; z < w; z++) r[(5*y+x)*w + z] = b[x][y][z];
    return r;
  endfunction

  function automatic logic [1599:0] rand_vec();
    logic [1599:0] r;
    for (int i = 0; i < 50; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Scoreboards: expected {inv, data} in acceptance order.
  logic [1600:0] a_q[$];
  logic [1600:0] b_q[$];
  int a_edges, b_edges;
  int a_outs = 0, b_outs = 0, b_ins = 0;
  logic          a_hold, b_hold, a_popped, b_popped;
  logic [1600:0] a_hold_v, b_hold_v, a_last, b_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin a_edges <= 0; b_edges <= 0; end
    else begin
      if (a_edges < 2) a_edges <= a_edges + 1;
      if (b_edges < 2) b_edges <= b_edges + 1;
    end
  end

  // Monitor A: occupancy-derived flags, hold stability, idle value, ordered results.
  always @(negedge clk) begin
    logic [1600:0] e;
    if (!rst_n) begin
      a_q.delete(); a_hold = 1'b0; a_popped = 1'b0; a_last = '0;
    end else begin
      check("a_busy", a_busy, a_q.size() != 0);
      check("a_valid", a_out_valid, a_q.size() != 0);
      if (a_edges > 0) check("a_ready", a_in_ready, a_q.size() < 2);
      else             check("a_ready_rel", a_in_ready, 0);
      if (a_hold) check("a_hold", {a_out_inv, a_out_data}, a_hold_v);
      if (!a_out_valid) check("a_idle", {a_out_inv, a_out_data}, a_popped ? a_last : '0);
      if (a_out_valid && a_out_ready && a_q.size() != 0) begin
        e = a_q.pop_front();
        check("a_out", {a_out_inv, a_out_data}, e);
        a_last = e; a_popped = 1'b1; a_outs++;
      end
      a_hold   = a_out_valid && !a_out_ready;
      a_hold_v = {a_out_inv, a_out_data};
      if (a_in_valid && a_in_ready) a_q.push_back({a_in_inv, model(a_in_data, a_in_inv, 64)});
    end
  end

  // Monitor B: same checks for the W=16, DEPTH=3 instance.
  always @(negedge clk) begin
    logic [1600:0] e;
    logic [1599:0] ext;
    if (!rst_n) begin
      b_q.delete(); b_hold = 1'b0; b_popped = 1'b0; b_last = '0;
    end else begin
      check("b_busy", b_busy, b_q.size() != 0);
      check("b_valid", b_out_valid, b_q.size() != 0);
      if (b_edges > 0) check("b_ready", b_in_ready, b_q.size() < 3);
      else             check("b_ready_rel", b_in_ready, 0);
      if (b_hold) check("b_hold", {b_out_inv, 1200'b0, b_out_data}, b_hold_v);
      if (!b_out_valid) check("b_idle", {b_out_inv, 1200'b0, b_out_data}, b_popped ? b_last : '0);
      if (b_out_valid && b_out_ready && b_q.size() != 0) begin
        e = b_q.pop_front();
        check("b_out", {b_out_inv, 1200'b0, b_out_data}, e);
        b_last = e; b_popped = 1'b1; b_outs++;
      end
      b_hold   = b_out_valid && !b_out_ready;
      b_hold_v = {b_out_inv, 1200'b0, b_out_data};
      if (b_in_valid && b_in_ready) begin
        ext = {1200'b0, b_in_data};
        b_q.push_back({b_in_inv, model(ext, b_in_inv, 16)});
        b_ins++;
      end
    end
  end

  // Offer one state to A until accepted; starts and ends just after a rising edge.
  task automatic a_send(input logic [1599:0] d, input logic inv);
    bit ok;
    ok = 1'b0;
    a_in_valid = 1'b1; a_in_data = d; a_in_inv = inv;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("a_send_timeout", 0, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic b_send(input logic [399:0] d, input logic inv);
    bit ok;
    ok = 1'b0;
    b_in_valid = 1'b1; b_in_data = d; b_in_inv = inv;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("b_send_timeout", 0, 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1599:0] s, r, e;
    logic [1599:0] d [3];
    logic [399:0]  bs, br;
    int acc, idx, outs0;
    bit ok;

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_inv = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_inv = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_out_inv", a_out_inv, 0);
    check("rst_b_in_ready", b_in_ready, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready_before_edge", a_in_ready, 0);
    @(negedge clk);
    check("rel_ready_after_edge", a_in_ready, 1);
    @(posedge clk); #1;

    // Directed pattern: lane(x,y) = 5y+x, forward, one-cycle latency.
    a_out_ready = 1'b1;
    s = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) s[(5*y+x)*64 +: 64] = 64'(5*y + x);
    a_send(s, 1'b0);
    @(negedge clk);
    check("lat1_valid", a_out_valid, 1);
    if (RHO) e = model(s, 1'b0, 64);
    else begin
      e = '0;
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++) e[(5*y+x)*64 +: 64] = 64'(5*x + (x + 3*y) % 5);
    end
    check("pi_pattern", a_out_data, e);
    check("pi_pattern_inv", a_out_inv, 0);
    @(posedge clk); #1;

`ifdef SM_PI_PIPE_RHO_EN
    s = '0;
    s[64] = 1'b1;
    a_send(s, 1'b0);
    @(negedge clk);
    e = '0;
    e[10*64 +: 64] = 64'h2;
    check("rho_lane10", a_out_data, e);
    @(posedge clk); #1;
`endif

    // Round trips forward then inverse on both instances.
    for (int i = 0; i < 4; i++) begin
      s = rand_vec();
      a_send(s, 1'b0);
      @(negedge clk); r = a_out_data;
      @(posedge clk); #1;
      a_send(r, 1'b1);
      @(negedge clk);
      check("a_roundtrip", a_out_data, s);
      check("a_roundtrip_inv", a_out_inv, 1);
      @(posedge clk); #1;
    end
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s = rand_vec(); bs = s[399:0];
      b_send(bs, 1'b0);
      @(negedge clk); br = b_out_data;
      @(posedge clk); #1;
      b_send(br, 1'b1);
      @(negedge clk);
      check("b_roundtrip", b_out_data, bs);
      @(posedge clk); #1;
    end

    // Backpressure: three back-to-back offers into a two-entry buffer.
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) d[i] = rand_vec();
    acc = 0; idx = 0;
    a_in_valid = 1'b1; a_in_inv = 1'b0;
    repeat (4) begin
      a_in_data = d[idx];
      @(negedge clk);
      if (a_in_ready) begin acc++; if (idx < 2) idx++; end
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("bp_accepted", acc, 2);
    check("bp_ready_low", a_in_ready, 0);
    check("bp_busy", a_busy, 1);
    @(posedge clk); #1;
    outs0 = a_outs;
    a_out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_in_ready) begin ok = 1'b1; break; end
    end
    check("bp_third_accepted", ok, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("bp_results", a_outs - outs0, 3);

    // Streaming: 100 back-to-back transfers with out_ready held high.
    outs0 = a_outs;
    a_in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a_in_data = rand_vec(); a_in_inv = 1'($urandom % 2);
      @(negedge clk);
      check("stream_ready", a_in_ready, 1);
      if (i > 0) check("stream_valid", a_out_valid, 1);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    check("stream_last_valid", a_out_valid, 1);
    repeat (3) @(posedge clk); #1;
    check("stream_count", a_outs - outs0, 100);

    // Reset asserted mid-stream with two entries buffered.
    a_out_ready = 1'b0;
    a_send(rand_vec(), 1'b0);
    a_send(rand_vec(), 1'b1);
    @(negedge clk);
    check("pre_rst_busy", a_busy, 1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", a_out_valid, 0);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_ready", a_in_ready, 0);
    check("mid_rst_data", a_out_data, 0);
    check("mid_rst_inv", a_out_inv, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    a_out_ready = 1'b1;
    @(negedge clk);
    check("rst2_ready_before_edge", a_in_ready, 0);
    @(negedge clk);
    check("rst2_ready_after_edge", a_in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check("rst2_no_stale", a_out_valid, 0);
    end
    @(posedge clk); #1;

    // Random traffic on B with random backpressure.
    for (int i = 0; i < 300; i++) begin
      s = rand_vec();
      b_in_valid  = 1'($urandom % 2);
      b_in_inv    = 1'($urandom % 2);
      b_in_data   = s[399:0];
      b_out_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("b_count", b_outs, b_ins);
    check("b_drained", b_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
